mini_alu: RTL and testbench



---
 rtl/mini_alu.sv | 153 +++++++++++++++
 tb/tb_mini_alu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mini_alu.sv
// Multi-cycle 4-bit ALU: single-cycle add/sub, 4-iteration shift-add multiply and restoring divide.
// Optional div0_o sticky divide-by-zero flag is enabled with MINI_ALU_DIV0_FLAG_EN.
module mini_alu (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] op_i,
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] result_o,
    output logic       busy_o
`ifdef MINI_ALU_DIV0_FLAG_EN
    ,
    output logic       div0_o
`endif
);
    localparam int ITER = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [7:0] acc_q, acc_d;
    logic [3:0] rem_q, rem_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] result_q, result_d;
    logic       div0_q, div0_d;

    logic [7:0] mul_sum;
    logic [4:0] trial;
    logic       qbit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            div0_q   <= div0_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        div0_d   = div0_q;
        mul_sum  = '0;
        trial    = '0;
        qbit     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Any accepted request clears the sticky flag; divide-by-zero re-sets it below.
                if (op_i != 4'b0000) begin
                    div0_d = 1'b0;
                end
                if (op_i[3]) begin
                    result_d = {3'b000, {1'b0, a_i} + {1'b0, b_i}};
                    state_d  = S_DONE;
                end else if (op_i[2]) begin
                    result_d = {4'h0, a_i} - {4'h0, b_i};
                    state_d  = S_DONE;
                end else if (op_i[1]) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_MUL;
                end else if (op_i[0]) begin
                    if (b_i == 4'h0) begin
                        result_d = {4'hF, a_i};
                        div0_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        a_d     = a_i;
                        b_d     = b_i;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                mul_sum = acc_q + (b_q[0] ? ({4'h0, a_q} << cnt_q) : 8'h00);
                acc_d   = mul_sum;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + 2'd1;
                if (cnt_q == 2'(ITER - 1)) begin
                    result_d = mul_sum;
                    state_d  = S_DONE;
                end
            end
            S_DIV: begin
                // a_q shifts the dividend out MSB-first while quotient bits shift in at the LSB.
                trial = {rem_q, a_q[3]};
                if (trial >= {1'b0, b_q}) begin
                    rem_d = 4'(trial - {1'b0, b_q});
                    qbit  = 1'b1;
                end else begin
                    rem_d = trial[3:0];
                    qbit  = 1'b0;
                end
                a_d   = {a_q[2:0], qbit};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'(ITER - 1)) begin
                    result_d = {a_q[2:0], qbit, rem_d};
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (op_i == 4'b0000) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign result_o = result_q;
    assign busy_o   = (op_i != 4'b0000) && (state_q != S_DONE);

`ifdef MINI_ALU_DIV0_FLAG_EN
    assign div0_o = div0_q;
`else
    logic unused_div0;
    assign unused_div0 = div0_q;
`endif

endmodule

// File: tb/tb_mini_alu.sv
// Self-checking bench for mini_alu: per-cycle compare against a latency/arithmetic model plus directed literals.
module tb_mini_alu;
    logic       clk;
    logic       rst;
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] result;
    logic       busy;
`ifdef MINI_ALU_DIV0_FLAG_EN
    logic       div0;
`endif

    int checks   = 0;
    int failures = 0;

    mini_alu dut (
        .clk      (clk),
        .rst      (rst),
        .op_i     (op),
        .a_i      (a),
        .b_i      (b),
        .result_o (result),
        .busy_o   (busy)
`ifdef MINI_ALU_DIV0_FLAG_EN
        ,
        .div0_o   (div0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: value of a request from plain arithmetic, plus how many extra cycles it takes.
    function automatic logic [7:0] model_value(input logic [3:0] o, input logic [3:0] x, input logic [3:0] y);
        int xi;
        int yi;
        int v;
        xi = int'(x);
        yi = int'(y);
        if (o[3])      v = xi + yi;
        else if (o[2]) v = (xi - yi + 256) % 256;
        else if (o[1]) v = xi * yi;
        else if (yi == 0) v = 240 + xi;
        else           v = (xi / yi) * 16 + (xi % yi);
        return 8'(v);
    endfunction

    function automatic bit model_long(input logic [3:0] o, input logic [3:0] y);
        if (o[3] || o[2]) return 1'b0;
        if (o[1]) return 1'b1;
        return (y != 4'h0);
    endfunction

    logic [7:0] m_res;
    logic [7:0] m_pend;
    logic       m_done;
    logic       m_div0;
    int         m_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_res  <= 8'h00;
            m_pend <= 8'h00;
            m_done <= 1'b0;
            m_div0 <= 1'b0;
            m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_res  <= m_pend;
                m_done <= 1'b1;
            end
        end else if (m_done) begin
            if (op == 4'h0) m_done <= 1'b0;
        end else if (op != 4'h0) begin
            m_div0 <= (op == 4'b0001) && (b == 4'h0);
            if (model_long(op, b)) begin
                m_pend <= model_value(op, a, b);
                m_left <= 4;
            end else begin
                m_res  <= model_value(op, a, b);
                m_done <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_busy", {7'h0, busy}, {7'h0, (op != 4'h0) && !m_done});
        check("cyc_result", result, m_res);
`ifdef MINI_ALU_DIV0_FLAG_EN
        check("cyc_div0", {7'h0, div0}, {7'h0, m_div0});
`endif
    end

    task automatic run(input string name, input logic [3:0] o, input logic [3:0] x, input logic [3:0] y,
                       input logic [7:0] exp_res, input int exp_busy, input bit scramble);
        int nb;
        nb = 0;
        @(posedge clk);
        #2;
        op = o;
        a  = x;
        b  = y;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (!busy) break;
            nb++;
            if (scramble && nb == 2) begin
                a = 4'h0;
                b = 4'h0;
            end
            @(posedge clk);
            #2;
        end
        check({name, "_busy_cycles"}, 8'(nb), 8'(exp_busy));
        check({name, "_result"}, result, exp_res);
        $display("txn %s op=%b a=%h b=%h result=%h busy_cycles=%0d", name, o, x, y, result, nb);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            check({name, "_hold_busy"}, {7'h0, busy}, 8'h00);
        end
        check({name, "_hold_result"}, result, exp_res);
        op = 4'h0;
        @(posedge clk);
        #2;
        check({name, "_idle_result"}, result, exp_res);
    endtask

    initial begin
        rst = 1'b1;
        op  = 4'h0;
        a   = 4'h0;
        b   = 4'h0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("reset_result", result, 8'h00);
        check("reset_busy", {7'h0, busy}, 8'h00);

        run("div0", 4'b0001, 4'h9, 4'h0, 8'hF9, 1, 1'b0);
`ifdef MINI_ALU_DIV0_FLAG_EN
        check("div0_flag_set", {7'h0, div0}, 8'h01);
`endif
        run("add", 4'b1000, 4'h9, 4'h4, 8'h0D, 1, 1'b0);
`ifdef MINI_ALU_DIV0_FLAG_EN
        check("div0_flag_clr", {7'h0, div0}, 8'h00);
`endif
        run("sub", 4'b0100, 4'h3, 4'h5, 8'hFE, 1, 1'b0);
        run("mul", 4'b0010, 4'hF, 4'hF, 8'hE1, 5, 1'b1);
        run("div", 4'b0001, 4'hD, 4'h4, 8'h31, 5, 1'b1);
        run("prio_mul", 4'b0011, 4'h6, 4'h2, 8'h0C, 5, 1'b0);
        run("prio_add", 4'b1010, 4'h7, 4'h8, 8'h0F, 1, 1'b0);
        run("div_small", 4'b0001, 4'h2, 4'h7, 8'h02, 5, 1'b0);

        // Reset between clock edges during the third multiply iteration.
        @(posedge clk);
        #2;
        op = 4'b0010;
        a  = 4'h7;
        b  = 4'h3;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        op  = 4'h0;
        #1;
        check("async_rst_busy", {7'h0, busy}, 8'h00);
        check("async_rst_result", result, 8'h00);
        $display("txn async_reset result=%h busy=%b", result, busy);
        #2;
        rst = 1'b0;
        run("post_rst_add", 4'b1000, 4'hF, 4'hF, 8'h1E, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
